// File: rtl/vec_dispatch_sequencer_pkg.sv
// Shared types and constants for the vector dispatch sequencer: micro-op layout,
// group-size limits, FSM states and the beat-building helpers.
package vec_dispatch_sequencer_pkg;

   localparam int VEC_MAX_NREGS = 8;
   localparam int VEC_CNT_W     = $clog2(VEC_MAX_NREGS) + 1;
   localparam int VEC_LANE_W    = VEC_CNT_W - 1;
   localparam int NR_BITS       = 5;
   localparam int OP_W          = 4;

   typedef enum logic {VSEQ_IDLE, VSEQ_EXPAND} vseq_state_e;

   typedef struct packed {
      logic [OP_W-1:0]       op_type;
      logic                  is_vec;
      logic [NR_BITS-1:0]    vd;
      logic [NR_BITS-1:0]    vs1;
      logic [VEC_LANE_W-1:0] vd_lane_id;
      logic                  vd_is_last;
   } dispatch_t;

   localparam int DISPATCH_W = $bits(dispatch_t);

   // Zero means a one-register group; oversize requests saturate at the LMUL limit.
   function automatic logic [VEC_CNT_W-1:0] clamp_nregs(input logic [VEC_CNT_W-1:0] n);
      if (n == '0) return VEC_CNT_W'(1);
      if (n > VEC_CNT_W'(VEC_MAX_NREGS)) return VEC_CNT_W'(VEC_MAX_NREGS);
      return n;
   endfunction

   function automatic dispatch_t make_beat(input dispatch_t base,
                                           input logic [VEC_CNT_W-1:0] idx,
                                           input logic last);
      dispatch_t b;
      b            = base;
      b.vd         = base.vd + NR_BITS'(idx);
      b.vd_lane_id = VEC_LANE_W'(idx);
      b.vd_is_last = last;
      return b;
   endfunction

endpackage

// File: rtl/vec_seq_out_reg.sv
// One-entry valid/ready pipe register with load, flush and a FREE indication
// that tells the producer a new entry may be loaded this cycle.
module vec_seq_out_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         free
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   assign free      = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: state flops use non-blocking assignments only; the data register is reset too so out.data reads 0 after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/vec_dispatch_sequencer.sv
// Expands vector dispatches into per-register micro-ops (vd=base+i, lane i, last on
// the final beat); scalar dispatches pass through as one beat. Registered output.
module vec_dispatch_sequencer
   import vec_dispatch_sequencer_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  dispatch_in_valid,
   input  logic [DISPATCH_W-1:0] dispatch_in_data,
   output logic                  dispatch_in_ready,
   input  logic [VEC_CNT_W-1:0]  in_nregs,
   output logic                  dispatch_out_valid,
   output logic [DISPATCH_W-1:0] dispatch_out_data,
   input  logic                  dispatch_out_ready,
   output logic                  busy,
   output logic [31:0]           perf_beats
);

   vseq_state_e          state_q, state_d;
   logic [VEC_CNT_W-1:0] cnt_q, cnt_d;
   logic [VEC_CNT_W-1:0] cap_n_q, cap_n_d;
   dispatch_t            cap_q, cap_d;
   logic [31:0]          perf_q, perf_d;

   dispatch_t            in_beat;
   dispatch_t            load_beat;
   logic [VEC_CNT_W-1:0] n_in;
   logic                 load;
   logic                 free;
   logic                 last_beat;

   assign in_beat = dispatch_t'(dispatch_in_data);
   assign n_in    = clamp_nregs(in_nregs);

   always_comb begin
      state_d           = state_q;
      cnt_d             = cnt_q;
      cap_d             = cap_q;
      cap_n_d           = cap_n_q;
      load              = 1'b0;
      load_beat         = cap_q;
      last_beat         = 1'b0;
      dispatch_in_ready = 1'b0;
      // Downstream handshakes count even in a flush cycle.
      perf_d            = perf_q + 32'(dispatch_out_valid && dispatch_out_ready);

      case (state_q)
         VSEQ_IDLE: begin
            dispatch_in_ready = free && !flush;
            if (dispatch_in_valid && dispatch_in_ready) begin
               load = 1'b1;
               if (!in_beat.is_vec) begin
                  load_beat = make_beat(in_beat, '0, 1'b1);
               end else begin
                  load_beat = make_beat(in_beat, '0, n_in == VEC_CNT_W'(1));
                  if (n_in > VEC_CNT_W'(1)) begin
                     cap_d   = in_beat;
                     cap_n_d = n_in;
                     cnt_d   = VEC_CNT_W'(1);
                     state_d = VSEQ_EXPAND;
                  end
               end
            end
         end
         VSEQ_EXPAND: begin
            if (free) begin
               last_beat = (cnt_q == cap_n_q - 1'b1);
               load      = 1'b1;
               load_beat = make_beat(cap_q, cnt_q, last_beat);
               cnt_d     = cnt_q + 1'b1;
               if (last_beat) begin
                  cnt_d   = '0;
                  state_d = VSEQ_IDLE;
               end
            end
         end
         default: state_d = VSEQ_IDLE;
      endcase

      if (flush) begin
         state_d = VSEQ_IDLE;
         cnt_d   = '0;
         load    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= VSEQ_IDLE;
         cnt_q   <= '0;
         cap_n_q <= '0;
         cap_q   <= '0;
         perf_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_n_q <= cap_n_d;
         cap_q   <= cap_d;
         perf_q  <= perf_d;
      end
   end

   vec_seq_out_reg #(.W(DISPATCH_W)) u_out_reg (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .load      (load),
      .load_data (load_beat),
      .out_ready (dispatch_out_ready),
      .out_valid (dispatch_out_valid),
      .out_data  (dispatch_out_data),
      .free      (free)
   );

   assign busy       = (state_q == VSEQ_EXPAND) || dispatch_out_valid;
   assign perf_beats = perf_q;

endmodule

// File: tb/tb_vec_dispatch_sequencer.sv
// Self-checking bench for vec_dispatch_sequencer: table-driven dispatches plus
// hand-written backpressure, flush and async-reset sequences, scoreboarded output.
module tb_vec_dispatch_sequencer;
   import vec_dispatch_sequencer_pkg::*;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  flush = 1'b0;
   logic                  in_valid = 1'b0;
   logic [DISPATCH_W-1:0] in_data = '0;
   logic                  in_ready;
   logic [VEC_CNT_W-1:0]  in_nregs = '0;
   logic                  out_valid;
   logic [DISPATCH_W-1:0] out_data;
   logic                  out_ready = 1'b1;
   logic                  busy;
   logic [31:0]           perf_beats;

   int checks = 0;
   int errors = 0;
   dispatch_t exp_q[$];

   typedef struct {
      logic [OP_W-1:0]      op;
      logic                 is_vec;
      logic [NR_BITS-1:0]   vd;
      logic [NR_BITS-1:0]   vs1;
      logic [VEC_CNT_W-1:0] nregs;
      int                   exp_beats;
   } vec_t;

   vec_t tbl[7];

   always #5 clk = ~clk;

   vec_dispatch_sequencer dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .flush              (flush),
      .dispatch_in_valid  (in_valid),
      .dispatch_in_data   (in_data),
      .dispatch_in_ready  (in_ready),
      .in_nregs           (in_nregs),
      .dispatch_out_valid (out_valid),
      .dispatch_out_data  (out_data),
      .dispatch_out_ready (out_ready),
      .busy               (busy),
      .perf_beats         (perf_beats)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beats(input dispatch_t d, input int n);
      for (int i = 0; i < n; i++) begin
         dispatch_t b;
         b            = d;
         b.vd         = d.vd + NR_BITS'(i);
         b.vd_lane_id = VEC_LANE_W'(i);
         b.vd_is_last = (i == n - 1);
         exp_q.push_back(b);
      end
   endtask

   function automatic dispatch_t mk(input logic [OP_W-1:0] op, input logic is_vec,
                                    input logic [NR_BITS-1:0] vd, input logic [NR_BITS-1:0] vs1);
      dispatch_t d;
      d.op_type    = op;
      d.is_vec     = is_vec;
      d.vd         = vd;
      d.vs1        = vs1;
      d.vd_lane_id = VEC_LANE_W'(5);
      d.vd_is_last = 1'b0;
      return d;
   endfunction

   // Drives one dispatch, waits (bounded) for acceptance and returns one cycle
   // after the handshake edge, when beat 0 must already be on the output.
   task automatic send(input dispatch_t d, input logic [VEC_CNT_W-1:0] nr, input int n_exp);
      int guard;
      guard    = 0;
      in_data  = d;
      in_nregs = nr;
      in_valid = 1'b1;
      while (!in_ready && guard < 100) begin
         tick();
         guard++;
      end
      check("in_ready_wait", 32'(guard < 100), 32'd1);
      push_beats(d, n_exp);
      tick();
      in_valid = 1'b0;
      check("latency_out_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || out_valid) && g < 200) begin
         tick();
         g++;
      end
      check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
      check("drain_out_idle", 32'(out_valid), 32'd0);
   endtask

   // Scoreboard: every downstream handshake must match the oldest expected beat.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         check("beat_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            dispatch_t e;
            e = exp_q.pop_front();
            check("beat_data", 32'(out_data), 32'(e));
         end
      end
   end

   initial begin
      dispatch_t   o;
      logic [31:0] perf0;
      logic [DISPATCH_W-1:0] held;
      int total;

      tbl[0] = '{4'h3, 1'b0, 5'd5,  5'd1, 4'd1,  1};
      tbl[1] = '{4'h7, 1'b1, 5'd8,  5'd2, 4'd4,  4};
      tbl[2] = '{4'h1, 1'b1, 5'd31, 5'd3, 4'd2,  2};
      tbl[3] = '{4'h2, 1'b1, 5'd12, 5'd4, 4'd0,  1};
      tbl[4] = '{4'h4, 1'b1, 5'd16, 5'd5, 4'd11, 8};
      tbl[5] = '{4'h5, 1'b1, 5'd7,  5'd6, 4'd1,  1};
      tbl[6] = '{4'h6, 1'b0, 5'd9,  5'd7, 4'd7,  1};

      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_data", 32'(out_data), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_perf", perf_beats, 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      reset_n = 1'b1;
      tick();

      // Table: scalar, vectors, wrap, nregs=0 and oversize clamp, back to back.
      perf0 = perf_beats;
      total = 0;
      for (int i = 0; i < 7; i++) begin
         send(mk(tbl[i].op, tbl[i].is_vec, tbl[i].vd, tbl[i].vs1), tbl[i].nregs, tbl[i].exp_beats);
         total += tbl[i].exp_beats;
      end
      drain();
      check("table_perf", perf_beats, perf0 + 32'(total));

      // N=4 one beat per cycle; input reopens while the last beat is shown.
      perf0 = perf_beats;
      send(mk(4'h8, 1'b1, 5'd8, 5'd0), 4'd4, 4);
      for (int i = 0; i < 4; i++) begin
         o = dispatch_t'(out_data);
         check("n4_valid", 32'(out_valid), 32'd1);
         check("n4_lane", 32'(o.vd_lane_id), 32'(i));
         check("n4_in_ready", 32'(in_ready), 32'(i == 3));
         tick();
      end
      check("n4_done_valid", 32'(out_valid), 32'd0);
      check("n4_perf", perf_beats, perf0 + 32'd4);

      // Backpressure: beat 0 held stable, beat 1 only after the handshake.
      send(mk(4'h9, 1'b1, 5'd3, 5'd2), 4'd2, 2);
      out_ready = 1'b0;
      held = out_data;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_valid_held", 32'(out_valid), 32'd1);
         check("bp_data_stable", 32'(out_data), 32'(held));
      end
      out_ready = 1'b1;
      tick();
      o = dispatch_t'(out_data);
      check("bp_beat1_lane", 32'(o.vd_lane_id), 32'd1);
      check("bp_beat1_last", 32'(o.vd_is_last), 32'd1);
      tick();
      check("bp_done_valid", 32'(out_valid), 32'd0);
      check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

      // Flush mid-expansion while beat 3 is on the output and being accepted.
      send(mk(4'ha, 1'b1, 5'd0, 5'd1), 4'd8, 8);
      repeat (3) tick();
      o = dispatch_t'(out_data);
      check("fl_lane3", 32'(o.vd_lane_id), 32'd3);
      flush = 1'b1;
      perf0 = perf_beats;
      #1;
      check("fl_in_ready_low", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0;
      exp_q.delete();
      #1;
      check("fl_out_valid", 32'(out_valid), 32'd0);
      check("fl_busy", 32'(busy), 32'd0);
      check("fl_in_ready", 32'(in_ready), 32'd1);
      check("fl_perf", perf_beats, perf0 + 32'd1);
      send(mk(4'hb, 1'b1, 5'd20, 5'd2), 4'd2, 2);
      drain();

      // Async reset between edges mid-expansion.
      send(mk(4'hc, 1'b1, 5'd10, 5'd3), 4'd8, 8);
      repeat (2) tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_perf", perf_beats, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("rst_no_partial", 32'(out_valid), 32'd0);
      send(mk(4'h3, 1'b0, 5'd5, 5'd4), 4'd3, 1);
      drain();
      check("rst_perf_after", perf_beats, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
